// File: rtl/nbit_cmp_tracker.sv
`default_nettype none
// ============================================================================
// Module   : nbit_cmp_tracker
// Brief    : Registered, valid/ready handshaked N-bit magnitude comparator.
//            Keeps a running max/min of accepted 'a' and saturating counts
//            of each compare outcome.
// Config   : NBIT_CMP_SIGNED_EN - when defined, signed_mode selects a
//            two's-complement compare. When undefined, all ordering is
//            unsigned and signed_mode is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module nbit_cmp_tracker #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             signed_mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_greater,
  output logic             a_equal,
  output logic             a_lesser,
  output logic [N-1:0]     run_max,
  output logic [N-1:0]     run_min,
  output logic             stats_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Map a value onto a key whose unsigned order matches the requested
  // compare order. Flipping the sign bit turns two's-complement order into
  // unsigned order, so one unsigned comparator serves both modes.
  function automatic logic [N-1:0] order_key(input logic [N-1:0] v);
`ifdef NBIT_CMP_SIGNED_EN
    return {v[N-1] ^ signed_mode, v[N-2:0]};
`else
    return v;
`endif
  endfunction

`ifndef NBIT_CMP_SIGNED_EN
  // The mode port stays on the boundary but has no function in this build.
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic             accept;
  logic [N-1:0]     a_key;
  logic [N-1:0]     b_key;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;

  // Statistics as seen after an optional clear in this cycle; an accepted
  // sample is then applied on top, so clear+accept yields a fresh first sample.
  logic             base_valid;
  logic [N-1:0]     base_max;
  logic [N-1:0]     base_min;
  logic [CNT_W-1:0] base_gt;
  logic [CNT_W-1:0] base_eq;
  logic [CNT_W-1:0] base_lt;
  logic             a_above_max;
  logic             a_below_min;

  // Ready depends only on the output stage, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign a_key  = order_key(a);
  assign b_key  = order_key(b);
  assign cmp_gt = a_key > b_key;
  assign cmp_lt = a_key < b_key;
  assign cmp_eq = !cmp_gt && !cmp_lt;

  assign base_valid = stats_valid && !clear;
  assign base_max   = clear ? '0 : run_max;
  assign base_min   = clear ? '0 : run_min;
  assign base_gt    = clear ? '0 : gt_cnt;
  assign base_eq    = clear ? '0 : eq_cnt;
  assign base_lt    = clear ? '0 : lt_cnt;

  // History keeps its stored bits; only the incoming compare mode applies.
  assign a_above_max = a_key > order_key(base_max);
  assign a_below_min = a_key < order_key(base_min);

  // Output stage: load on accept, drop valid on consume, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_greater <= 1'b0;
      a_equal   <= 1'b0;
      a_lesser  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a_greater <= cmp_gt;
      a_equal   <= cmp_eq;
      a_lesser  <= cmp_lt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Running statistics: clear first, then fold in the accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      stats_valid <= 1'b0;
      run_max     <= '0;
      run_min     <= '0;
      gt_cnt      <= '0;
      eq_cnt      <= '0;
      lt_cnt      <= '0;
    end else if (accept) begin
      stats_valid <= 1'b1;
      if (!base_valid) begin
        run_max <= a;
        run_min <= a;
      end else begin
        run_max <= a_above_max ? a : base_max;
        run_min <= a_below_min ? a : base_min;
      end
      gt_cnt <= cmp_gt ? sat_inc(base_gt) : base_gt;
      eq_cnt <= cmp_eq ? sat_inc(base_eq) : base_eq;
      lt_cnt <= cmp_lt ? sat_inc(base_lt) : base_lt;
    end else begin
      stats_valid <= base_valid;
      run_max     <= base_max;
      run_min     <= base_min;
      gt_cnt      <= base_gt;
      eq_cnt      <= base_eq;
      lt_cnt      <= base_lt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nbit_cmp_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbit_cmp_tracker
// Brief    : Directed self-checking bench for nbit_cmp_tracker (N=8,
//            CNT_W=2 so counter saturation is reachable in a few pairs).
//            Signed expectations follow NBIT_CMP_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbit_cmp_tracker;

  localparam int N     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             signed_mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic             a_greater;
  logic             a_equal;
  logic             a_lesser;
  logic [N-1:0]     run_max;
  logic [N-1:0]     run_min;
  logic             stats_valid;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  nbit_cmp_tracker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_greater(a_greater), .a_equal(a_equal), .a_lesser(a_lesser),
    .run_max(run_max), .run_min(run_min), .stats_valid(stats_valid),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    clear = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({out_valid, a_greater, a_equal, a_lesser, stats_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {out_valid, a_greater, a_equal, a_lesser, stats_valid});
    end
    n_cmp++;
    if ({run_max, run_min, gt_cnt, eq_cnt, lt_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_stats: max=%h min=%h gt=%0d eq=%0d lt=%0d want all 0",
               run_max, run_min, gt_cnt, eq_cnt, lt_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'd5; b = 8'd3;
    step();
    n_cmp++;
    if ({out_valid, a_greater, a_equal, a_lesser} !== 4'b1100) begin
      n_bad++;
      $display("FAIL basic_gt: got %b want 1100", {out_valid, a_greater, a_equal, a_lesser});
    end
    a = 8'd3; b = 8'd3;
    step();
    n_cmp++;
    if ({out_valid, a_greater, a_equal, a_lesser} !== 4'b1010) begin
      n_bad++;
      $display("FAIL basic_eq: got %b want 1010", {out_valid, a_greater, a_equal, a_lesser});
    end
    a = 8'd2; b = 8'd9;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, a_greater, a_equal, a_lesser} !== 4'b1001) begin
      n_bad++;
      $display("FAIL basic_lt: got %b want 1001", {out_valid, a_greater, a_equal, a_lesser});
    end
    n_cmp++;
    if ({gt_cnt, eq_cnt, lt_cnt} !== {2'd1, 2'd1, 2'd1}) begin
      n_bad++;
      $display("FAIL basic_counts: got %0d/%0d/%0d want 1/1/1", gt_cnt, eq_cnt, lt_cnt);
    end
    n_cmp++;
    if (run_max !== 8'd5 || run_min !== 8'd2 || stats_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_maxmin: got max=%0d min=%0d sv=%b want 5 2 1",
               run_max, run_min, stats_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || a_lesser !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_drain: got ov=%b lt=%b want ov=0 lt=1 (held)", out_valid, a_lesser);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_signed();
    do_clear();
    n_cmp++;
    if ({stats_valid, run_max, run_min, gt_cnt, eq_cnt, lt_cnt} !== '0) begin
      n_bad++;
      $display("FAIL clear_only: sv=%b max=%h min=%h cnt=%0d/%0d/%0d want all 0",
               stats_valid, run_max, run_min, gt_cnt, eq_cnt, lt_cnt);
    end
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; signed_mode = 1'b1;
    step();
`ifdef NBIT_CMP_SIGNED_EN
    n_cmp++;
    if ({a_greater, a_equal, a_lesser} !== 3'b001) begin
      n_bad++;
      $display("FAIL signed_ff_vs_01: got %b want 001", {a_greater, a_equal, a_lesser});
    end
`else
    n_cmp++;
    if ({a_greater, a_equal, a_lesser} !== 3'b100) begin
      n_bad++;
      $display("FAIL mode_ignored_ff_vs_01: got %b want 100", {a_greater, a_equal, a_lesser});
    end
`endif
    signed_mode = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({a_greater, a_equal, a_lesser} !== 3'b100) begin
      n_bad++;
      $display("FAIL unsigned_ff_vs_01: got %b want 100", {a_greater, a_equal, a_lesser});
    end
`ifdef NBIT_CMP_SIGNED_EN
    n_cmp++;
    if ({gt_cnt, eq_cnt, lt_cnt} !== {2'd1, 2'd0, 2'd1}) begin
      n_bad++;
      $display("FAIL signed_counts: got %0d/%0d/%0d want 1/0/1", gt_cnt, eq_cnt, lt_cnt);
    end
`else
    n_cmp++;
    if ({gt_cnt, eq_cnt, lt_cnt} !== {2'd2, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL unsigned_counts: got %0d/%0d/%0d want 2/0/0", gt_cnt, eq_cnt, lt_cnt);
    end
`endif
    n_cmp++;
    if (run_max !== 8'hFF || run_min !== 8'hFF) begin
      n_bad++;
      $display("FAIL mode_maxmin: got max=%h min=%h want ff ff", run_max, run_min);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_clear();
    out_ready = 1'b0; in_valid = 1'b1; a = 8'd4; b = 8'd6;
    step();
    a = 8'd9; b = 8'd1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({out_valid, a_greater, a_equal, a_lesser} !== 4'b1001 || gt_cnt !== 2'd0
          || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got res=%b gt=%0d rdy=%b want 1001 0 0", i,
                 {out_valid, a_greater, a_equal, a_lesser}, gt_cnt, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ready_comb: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, a_greater, a_lesser} !== 3'b110 || gt_cnt !== 2'd1 || lt_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL bp_second: got res=%b gt=%0d lt=%0d want 110 1 1",
               {out_valid, a_greater, a_lesser}, gt_cnt, lt_cnt);
    end
    n_cmp++;
    if (run_max !== 8'd9 || run_min !== 8'd4) begin
      n_bad++;
      $display("FAIL bp_maxmin: got max=%0d min=%0d want 9 4", run_max, run_min);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd42; b = 8'd42;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (eq_cnt !== ((k > 3) ? 2'd3 : 2'(k)) || gt_cnt !== 2'd0 || lt_cnt !== 2'd0) begin
        n_bad++;
        $display("FAIL sat[%0d]: got %0d/%0d/%0d want 0/%0d/0", k,
                 gt_cnt, eq_cnt, lt_cnt, (k > 3) ? 3 : k);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_clear_accept();
    clear = 1'b1; in_valid = 1'b1; a = 8'd7; b = 8'd1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({gt_cnt, eq_cnt, lt_cnt} !== {2'd1, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL clr_acc_counts: got %0d/%0d/%0d want 1/0/0", gt_cnt, eq_cnt, lt_cnt);
    end
    n_cmp++;
    if (run_max !== 8'd7 || run_min !== 8'd7 || stats_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_acc_stats: got max=%0d min=%0d sv=%b want 7 7 1",
               run_max, run_min, stats_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; a = 8'd3; b = 8'd8;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || a_lesser !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_pre: got ov=%b lt=%b want 1 1", out_valid, a_lesser);
    end
    rst = 1'b1; out_ready = 1'b1; a = 8'd2; b = 8'd2;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, a_greater, a_equal, a_lesser, stats_valid} !== 5'b0
        || {run_max, run_min, gt_cnt, eq_cnt, lt_cnt} !== '0) begin
      n_bad++;
      $display("FAIL rm_reset: got flags=%b max=%h min=%h cnt=%0d/%0d/%0d want all 0",
               {out_valid, a_greater, a_equal, a_lesser, stats_valid},
               run_max, run_min, gt_cnt, eq_cnt, lt_cnt);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || eq_cnt !== 2'd0 || stats_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_dropped: got ov=%b eq=%0d sv=%b want 0 0 0",
               out_valid, eq_cnt, stats_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_saturation();
    test_clear_accept();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nbit_cmp_tracker.md
# nbit_cmp_tracker

Registered, handshaked N-bit magnitude comparator with running statistics. Each accepted pair (a, b) yields a registered greater/equal/lesser result one cycle later over a valid/ready stream. The block also tracks the running maximum and minimum of `a` and saturating counts of each comparison outcome. It sits downstream of sample sources in the datapath, where a compare result is needed alongside history, not just an instantaneous relation.

## Interface
- `N`, 8, operand width in bits (N ≥ 2).
- `CNT_W`, 16, width of each outcome counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair this cycle.
- `a`, `b`  in  N  operands.
- `signed_mode`  in  1  1 = two's-complement compare, 0 = unsigned; sampled with the pair.
- `clear`  in  1  synchronous clear of running statistics.
- `out_valid`  out  1  result registers hold an unconsumed result.
- `out_ready`  in  1  consumer accepts the result.
- `a_greater`, `a_equal`, `a_lesser`  out  1 each  one-hot compare result.
- `run_max`, `run_min`  out  N  running max/min of accepted `a`.
- `stats_valid`  out  1  at least one pair accepted since the last reset/clear.
- `gt_cnt`, `eq_cnt`, `lt_cnt`  out  CNT_W each  saturating outcome counts.

## Operation
- Accept when `in_valid && in_ready`; `in_ready = !out_valid || out_ready`, which allows full throughput of one pair per cycle.
- On accept: compare using the mode in force, register exactly one of gt/eq/lt, and set `out_valid`.
- Result and `out_valid` hold stable while `out_valid && !out_ready`.
- When `out_valid && out_ready` with no new accept, `out_valid` drops to 0. The flags keep their last value, and consumers must ignore them.
- Running stats update on accept, not on output consume. Max/min use the same signedness as the compare:
  - if `stats_valid` = 0, the first accept loads both `run_max` and `run_min` with `a`;
  - otherwise `run_max = max(run_max, a)` and `run_min = min(run_min, a)`.
- Counters increment on their outcome and saturate at 2^CNT_W−1 with no wrap.
- `clear`: zeroes the counters, `run_max`, `run_min` and `stats_valid`. It does not affect `out_valid` or the result flags.
- `clear` together with an accept: the clear applies first, then the sample. The accepted pair becomes the first sample, its counter is set to 1 and `stats_valid` = 1.
- `signed_mode` may change between pairs. Stats history is not reinterpreted when the mode changes.

## Timing
- Latency: accept in cycle t, result visible with `out_valid` = 1 in cycle t+1. Stats and counters are also updated in t+1.
- Reset values: `out_valid` 0, all three flags 0, `run_max`/`run_min` 0, `stats_valid` 0, all counters 0. `in_ready` is 1 out of reset.
- A reset mid-transaction discards any held result. The pair offered in the reset cycle is not accepted.
- `in_ready` is combinational from `out_valid` and `out_ready` only. It never depends on `in_valid`.

## Configuration
- `NBIT_CMP_SIGNED_EN` defined: `signed_mode` is honoured as described.
- Not defined: `signed_mode` is ignored. All compares and max/min are unsigned, and the signed-compare logic is not built. The port remains present.

## Test plan
- Reset release, N=8, unsigned. Pairs (5,3), (3,3), (2,9) on consecutive cycles with `out_ready` = 1 → results gt, eq, lt in cycles t+1..t+3; `gt_cnt`/`eq_cnt`/`lt_cnt` = 1/1/1; `run_max` 5, `run_min` 2.
- Signed mode (macro defined), a=8'hFF, b=8'h01 → lt. Same pair unsigned → gt. After only these two pairs, with no clear: `run_min` = 8'hFF is the value loaded by the first accept. It is unchanged by the second pair because in unsigned mode 8'hFF is not less than 8'hFF.
- Backpressure: hold `out_ready` = 0 after one accept → `in_ready` 0; result stable for 5 cycles; a second pair offered is not accepted until `out_ready` rises.
- Saturation, CNT_W=2: 5 consecutive equal pairs → `eq_cnt` = 3, other counters 0.
- `clear` asserted in the same cycle as accepting (7,1) → next cycle `gt_cnt` 1, others 0, `run_max` = `run_min` = 7, `stats_valid` 1.
- `rst` asserted while `out_valid` = 1 → next cycle all outputs at reset values and the offered pair is dropped.
